// File: rtl/ucie_sb_param_exchange_if.sv
// Bundle of the handshake and message buses around the parameter-exchange
// engine.
//   loc_*    : local capability word in from the training FSM (valid/ready)
//   neg_*    : negotiated word back to the training FSM (valid/ready)
//   sb_tx_*  : outgoing sideband message (valid/ready, 2-bit opcode)
//   sb_rx_*  : incoming sideband message strobe (no backpressure)
//   xchg_error, retry_cnt, xchg_state : status and debug
// Modport slave is the engine; modport master is its environment.
interface ucie_sb_param_exchange_if;
  logic [31:0] loc_param;
  logic        loc_valid;
  logic        loc_ready;
  logic [31:0] neg_param;
  logic        neg_valid;
  logic        neg_ready;
  logic [31:0] sb_tx_data;
  logic [1:0]  sb_tx_opcode;
  logic        sb_tx_valid;
  logic        sb_tx_ready;
  logic [31:0] sb_rx_data;
  logic [1:0]  sb_rx_opcode;
  logic        sb_rx_valid;
  logic        xchg_error;
  logic [3:0]  retry_cnt;
  logic [2:0]  xchg_state;

  modport slave (
    input  loc_param, loc_valid, neg_ready, sb_tx_ready,
           sb_rx_data, sb_rx_opcode, sb_rx_valid,
    output loc_ready, neg_param, neg_valid, sb_tx_data, sb_tx_opcode,
           sb_tx_valid, xchg_error, retry_cnt, xchg_state
  );

  modport master (
    output loc_param, loc_valid, neg_ready, sb_tx_ready,
           sb_rx_data, sb_rx_opcode, sb_rx_valid,
    input  loc_ready, neg_param, neg_valid, sb_tx_data, sb_tx_opcode,
           sb_tx_valid, xchg_error, retry_cnt, xchg_state
  );
endinterface

// File: rtl/ucie_sb_param_exchange.sv
// Sideband parameter-exchange engine.
// Takes the local capability word, sends it as a REQ, captures the partner's
// REQ, negotiates min(width), min(speed) and the AND of the protocol masks,
// confirms with ACK (resending on timeout) and hands the negotiated word back.
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : ucie_sb_param_exchange_if.slave (loc/neg handshakes, sideband tx/rx,
//          status)
// Parameters:
//   TIMEOUT_CYCLES : wait-state timeout in cycles (2..65535)
//   MAX_RETRIES    : timeout-triggered resends allowed before ERROR (0..15)
module ucie_sb_param_exchange #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  ucie_sb_param_exchange_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_REQ   = 3'd1,
    S_WAIT_REM = 3'd2,
    S_TX_ACK   = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  localparam logic [1:0]  OP_REQ    = 2'b01;
  localparam logic [1:0]  OP_ACK    = 2'b10;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [31:0] loc_q, loc_d;
  logic [31:0] rem_param_q, rem_param_d;
  logic [31:0] neg_param_q, neg_param_d;
  logic        rem_seen_q, rem_seen_d;
  logic        ack_seen_q, ack_seen_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;

  logic        loc_ready_q, loc_ready_d;
  logic        neg_valid_q, neg_valid_d;
  logic [31:0] sb_tx_data_q, sb_tx_data_d;
  logic [1:0]  sb_tx_opcode_q, sb_tx_opcode_d;
  logic        sb_tx_valid_q, sb_tx_valid_d;
  logic        xchg_error_q, xchg_error_d;

  logic [7:0]  neg_width;
  logic [7:0]  neg_speed;
  logic [15:0] neg_proto;
  logic [31:0] neg_word;
  logic        compat;
  logic        timeout;
  logic        retry_ok;
  logic        rem_set;
  logic        ack_set;
  logic        flag_clr;
  logic        next_is_wait;

  always_comb begin
    neg_width = (loc_q[31:24] < rem_param_q[31:24]) ? loc_q[31:24] : rem_param_q[31:24];
    neg_speed = (loc_q[23:16] < rem_param_q[23:16]) ? loc_q[23:16] : rem_param_q[23:16];
    neg_proto = loc_q[15:0] & rem_param_q[15:0];
    neg_word  = {neg_width, neg_speed, neg_proto};
    compat    = (neg_width != '0) && (neg_speed != '0) && (neg_proto != '0);
  end

  always_comb begin
    state_d     = state_q;
    loc_d       = loc_q;
    rem_param_d = rem_param_q;
    neg_param_d = neg_param_q;
    retry_cnt_d = retry_cnt_q;
    flag_clr    = 1'b0;
    rem_set     = 1'b0;
    ack_set     = 1'b0;

    timeout  = (timer_q == TMO_LAST);
    retry_ok = (retry_cnt_q < RETRY_MAX);

    // RX capture runs in every state.
    if (bus.sb_rx_valid && (bus.sb_rx_opcode == OP_REQ)) begin
      rem_param_d = bus.sb_rx_data;
      rem_set     = 1'b1;
    end
    if (bus.sb_rx_valid && (bus.sb_rx_opcode == OP_ACK)) begin
      ack_set = 1'b1;
    end

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.loc_valid) begin
          loc_d       = bus.loc_param;
          retry_cnt_d = '0;
          state_d     = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        if (bus.sb_tx_ready) state_d = S_WAIT_REM;
      end
      S_WAIT_REM: begin
        if (rem_seen_q) begin
          if (compat) begin
            neg_param_d = neg_word;
            state_d     = S_TX_ACK;
          end else begin
            state_d = S_ERROR;
          end
        end else if (timeout) begin
          if (retry_ok) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            state_d     = S_TX_REQ;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_TX_ACK: begin
        if (bus.sb_tx_ready) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_seen_q) begin
          state_d = S_DONE;
        end else if (timeout) begin
          if (retry_ok) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            state_d     = S_TX_ACK;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DONE: begin
        if (bus.neg_ready) begin
          flag_clr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set wins over the DONE clear.
    rem_seen_d = rem_set | (rem_seen_q & ~flag_clr);
    ack_seen_d = ack_set | (ack_seen_q & ~flag_clr);

    next_is_wait = (state_d == S_WAIT_REM) || (state_d == S_WAIT_ACK);
    if (next_is_wait && (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == S_WAIT_REM) || (state_q == S_WAIT_ACK)) begin
      timer_d = timer_q + 16'd1;
    end else begin
      timer_d = timer_q;
    end

    // Outputs are decoded from the next state and registered, so they match a
    // Moore decode of the state register cycle for cycle.
    loc_ready_d    = 1'b0;
    neg_valid_d    = 1'b0;
    sb_tx_data_d   = '0;
    sb_tx_opcode_d = '0;
    sb_tx_valid_d  = 1'b0;
    xchg_error_d   = 1'b0;
    case (state_d)
      S_IDLE:   loc_ready_d = 1'b1;
      S_ERROR: begin
        loc_ready_d  = 1'b1;
        xchg_error_d = 1'b1;
      end
      S_TX_REQ: begin
        sb_tx_valid_d  = 1'b1;
        sb_tx_opcode_d = OP_REQ;
        sb_tx_data_d   = loc_d;
      end
      S_TX_ACK: begin
        sb_tx_valid_d  = 1'b1;
        sb_tx_opcode_d = OP_ACK;
        sb_tx_data_d   = neg_param_d;
      end
      S_DONE:   neg_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      loc_q          <= '0;
      rem_param_q    <= '0;
      neg_param_q    <= '0;
      rem_seen_q     <= 1'b0;
      ack_seen_q     <= 1'b0;
      timer_q        <= '0;
      retry_cnt_q    <= '0;
      loc_ready_q    <= 1'b1;
      neg_valid_q    <= 1'b0;
      sb_tx_data_q   <= '0;
      sb_tx_opcode_q <= '0;
      sb_tx_valid_q  <= 1'b0;
      xchg_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      loc_q          <= loc_d;
      rem_param_q    <= rem_param_d;
      neg_param_q    <= neg_param_d;
      rem_seen_q     <= rem_seen_d;
      ack_seen_q     <= ack_seen_d;
      timer_q        <= timer_d;
      retry_cnt_q    <= retry_cnt_d;
      loc_ready_q    <= loc_ready_d;
      neg_valid_q    <= neg_valid_d;
      sb_tx_data_q   <= sb_tx_data_d;
      sb_tx_opcode_q <= sb_tx_opcode_d;
      sb_tx_valid_q  <= sb_tx_valid_d;
      xchg_error_q   <= xchg_error_d;
    end
  end

  assign bus.loc_ready    = loc_ready_q;
  assign bus.neg_param    = neg_param_q;
  assign bus.neg_valid    = neg_valid_q;
  assign bus.sb_tx_data   = sb_tx_data_q;
  assign bus.sb_tx_opcode = sb_tx_opcode_q;
  assign bus.sb_tx_valid  = sb_tx_valid_q;
  assign bus.xchg_error   = xchg_error_q;
  assign bus.retry_cnt    = retry_cnt_q;
  assign bus.xchg_state   = state_q;

endmodule

// File: tb/tb_ucie_sb_param_exchange.sv
// Directed bench for ucie_sb_param_exchange with TIMEOUT_CYCLES=16,
// MAX_RETRIES=2. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_ucie_sb_param_exchange;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ucie_sb_param_exchange_if bus ();

  ucie_sb_param_exchange #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ack_tx_total = 0;
  int ack_snap;
  int req_cyc[$];
  int err_cyc;
  logic prev_req;

  // Accepted ACK messages, for "no ACK sent" checks.
  always @(posedge clk) begin
    if (!rst && bus.sb_tx_valid && bus.sb_tx_ready && (bus.sb_tx_opcode == 2'b10))
      ack_tx_total <= ack_tx_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.loc_param    = '0;
    bus.loc_valid    = 1'b0;
    bus.neg_ready    = 1'b0;
    bus.sb_tx_ready  = 1'b1;
    bus.sb_rx_data   = '0;
    bus.sb_rx_opcode = '0;
    bus.sb_rx_valid  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic rx_msg(input logic [1:0] op, input logic [31:0] data);
    bus.sb_rx_valid  = 1'b1;
    bus.sb_rx_opcode = op;
    bus.sb_rx_data   = data;
    tick();
    bus.sb_rx_valid  = 1'b0;
    bus.sb_rx_opcode = '0;
    bus.sb_rx_data   = '0;
  endtask

  task automatic send_loc(input logic [31:0] p);
    bus.loc_param = p;
    bus.loc_valid = 1'b1;
    tick();
    bus.loc_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    check("rst_state",     bus.xchg_state,   0);
    check("rst_loc_ready", bus.loc_ready,    1);
    check("rst_tx_valid",  bus.sb_tx_valid,  0);
    check("rst_tx_opcode", bus.sb_tx_opcode, 0);
    check("rst_neg_valid", bus.neg_valid,    0);
    check("rst_error",     bus.xchg_error,   0);
    check("rst_retry",     bus.retry_cnt,    0);
    check("rst_neg_param", bus.neg_param,    0);

    // Normal exchange
    ack_snap = ack_tx_total;
    send_loc(32'h4080_FFFF);
    check("n_req_state",  bus.xchg_state,   1);
    check("n_req_valid",  bus.sb_tx_valid,  1);
    check("n_req_opcode", bus.sb_tx_opcode, 2'b01);
    check("n_req_data",   bus.sb_tx_data,   32'h4080_FFFF);
    check("n_req_lready", bus.loc_ready,    0);
    tick();
    check("n_wait_rem", bus.xchg_state, 2);
    tick(); tick(); tick();
    rx_msg(2'b01, 32'h2040_000F);
    check("n_still_wait_rem", bus.xchg_state, 2);
    tick();
    check("n_ack_state",  bus.xchg_state,   3);
    check("n_ack_opcode", bus.sb_tx_opcode, 2'b10);
    check("n_ack_data",   bus.sb_tx_data,   32'h2040_000F);
    check("n_neg_param",  bus.neg_param,    32'h2040_000F);
    tick();
    check("n_wait_ack", bus.xchg_state, 4);
    tick(); tick();
    rx_msg(2'b10, 32'hDEAD_BEEF);
    check("n_still_wait_ack", bus.xchg_state, 4);
    tick();
    check("n_done_state", bus.xchg_state, 5);
    check("n_neg_valid",  bus.neg_valid,  1);
    tick(); tick();
    check("n_neg_valid_held", bus.neg_valid, 1);
    check("n_neg_param_held", bus.neg_param, 32'h2040_000F);
    bus.neg_ready = 1'b1;
    tick();
    bus.neg_ready = 1'b0;
    check("n_idle_state", bus.xchg_state, 0);
    check("n_idle_lready", bus.loc_ready, 1);
    check("n_idle_nvalid", bus.neg_valid, 0);
    check("n_ack_count", ack_tx_total - ack_snap, 1);

    // Early partner REQ
    do_reset();
    rx_msg(2'b01, 32'h2040_000F);
    send_loc(32'h4080_FFFF);
    check("e_req_state", bus.xchg_state, 1);
    tick();
    check("e_wait_rem", bus.xchg_state, 2);
    tick();
    check("e_ack_state", bus.xchg_state, 3);
    check("e_ack_data",  bus.sb_tx_data, 32'h2040_000F);
    check("e_retry",     bus.retry_cnt,  0);

    // Timeout and retry, partner silent
    do_reset();
    send_loc(32'h4080_FFFF);
    req_cyc.delete();
    err_cyc  = -1;
    prev_req = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if ((bus.xchg_state == 3'd1) && !prev_req) req_cyc.push_back(c);
      prev_req = (bus.xchg_state == 3'd1);
      if (bus.xchg_error) begin
        err_cyc = c;
        break;
      end
      tick();
    end
    check("t_req_count",  req_cyc.size(), 3);
    check("t_req1_cycle", (req_cyc.size() > 1) ? req_cyc[1] : -1, 17);
    check("t_req2_cycle", (req_cyc.size() > 2) ? req_cyc[2] : -1, 34);
    check("t_err_cycle",  err_cyc, 51);
    check("t_err_state",  bus.xchg_state, 6);
    check("t_err_retry",  bus.retry_cnt,  2);
    check("t_err_lready", bus.loc_ready,  1);
    tick(); tick();
    check("t_err_held", bus.xchg_error, 1);
    send_loc(32'h4080_FFFF);
    check("t_restart_state", bus.xchg_state, 1);
    check("t_restart_retry", bus.retry_cnt,  0);
    check("t_restart_error", bus.xchg_error, 0);

    // Incompatible protocols
    do_reset();
    ack_snap = ack_tx_total;
    rx_msg(2'b01, 32'h4080_000F);
    send_loc(32'h4080_00F0);
    tick();
    check("i_wait_rem", bus.xchg_state, 2);
    tick();
    check("i_err_state", bus.xchg_state, 6);
    check("i_err_flag",  bus.xchg_error, 1);
    check("i_retry",     bus.retry_cnt,  0);
    check("i_no_ack",    ack_tx_total - ack_snap, 0);

    // Backpressure, then ACK coinciding with timer expiry
    do_reset();
    rx_msg(2'b01, 32'h2040_000F);
    bus.sb_tx_ready = 1'b0;
    send_loc(32'h4080_FFFF);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("b_hold_state_%0d", i), bus.xchg_state, 1);
      check($sformatf("b_hold_data_%0d", i),  bus.sb_tx_data, 32'h4080_FFFF);
      check($sformatf("b_hold_valid_%0d", i), bus.sb_tx_valid, 1);
      tick();
    end
    check("b_still_req", bus.xchg_state, 1);
    bus.sb_tx_ready = 1'b1;
    tick();
    check("b_wait_rem", bus.xchg_state, 2);
    tick();
    check("b_tx_ack", bus.xchg_state, 3);
    tick();
    check("b_wait_ack", bus.xchg_state, 4);
    for (int i = 0; i < 14; i++) tick();
    rx_msg(2'b10, 32'h0);
    check("b_wait_ack_late", bus.xchg_state, 4);
    tick();
    check("b_done_state", bus.xchg_state, 5);
    check("b_done_retry", bus.retry_cnt,  0);

    // Mid-exchange reset during WAIT_ACK
    do_reset();
    rx_msg(2'b01, 32'h2040_000F);
    send_loc(32'h4080_FFFF);
    tick(); tick(); tick();
    check("r_wait_ack", bus.xchg_state, 4);
    rst = 1'b1;
    tick();
    check("r_state",     bus.xchg_state,   0);
    check("r_lready",    bus.loc_ready,    1);
    check("r_tx_valid",  bus.sb_tx_valid,  0);
    check("r_tx_opcode", bus.sb_tx_opcode, 0);
    check("r_tx_data",   bus.sb_tx_data,   0);
    check("r_neg_param", bus.neg_param,    0);
    check("r_neg_valid", bus.neg_valid,    0);
    check("r_error",     bus.xchg_error,   0);
    check("r_retry",     bus.retry_cnt,    0);
    rst = 1'b0;
    send_loc(32'h4080_FFFF);
    tick();
    tick();
    tick();
    check("r_flags_cleared", bus.xchg_state, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
